// File: rtl/data_memory_be.sv
// Byte-addressable data memory for the MEM stage: lane-enabled stores, registered
// sign/zero-extending loads, misalignment flagging and a post-reset clear sweep.
module data_memory_be #(
  parameter int DEPTH_BITS     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] Read_data,
  output logic        Read_valid,
  output logic        Busy,
  output logic        Misaligned
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  logic [31:0]           mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [DEPTH_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  mis_q, mis_d;

  logic                  busy;
  logic                  legal;
  logic [DEPTH_BITS-1:0] word_idx;
  logic [1:0]            offset;
  logic [3:0]            st_be;
  logic [31:0]           st_data;
  logic                  mem_we;
  logic [DEPTH_BITS-1:0] mem_idx;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [31:0]           load_val;
  logic                  unused_addr;

  assign busy        = (state_q == ST_INIT);
  assign word_idx    = Address[DEPTH_BITS+1:2];
  assign offset      = Address[1:0];
  assign unused_addr = ^Address[31:DEPTH_BITS+2];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    legal = 1'b0;
    case (MemSize)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~Address[0];
      2'b10:   legal = (offset == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    st_be   = 4'b0000;
    st_data = Write_data;
    case (MemSize)
      2'b00: begin
        st_be   = 4'b0001 << offset;
        st_data = {4{Write_data[7:0]}};
      end
      2'b01: begin
        st_be   = Address[1] ? 4'b1100 : 4'b0011;
        st_data = {2{Write_data[15:0]}};
      end
      2'b10:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_be    = st_be;
    mem_wdata = st_data;
    if (!rst) begin
      if (busy) begin
        if (CLEAR_ON_RESET) begin
          mem_we    = 1'b1;
          mem_idx   = cnt_q;
          mem_be    = 4'b1111;
          mem_wdata = '0;
        end
      end else if (MemWrite && legal) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: the array has no reset so it can map onto RAM; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // The word is read before this edge's store lands, giving read-before-write.
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {offset, 3'b000};

  always_comb begin
    load_val = rd_word;
    case (MemSize)
      2'b00:   load_val = {{24{MemSigned & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{MemSigned & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    rvalid_d = !busy && MemRead;
    mis_d    = !busy && (MemRead || MemWrite) && !legal;
    rdata_d  = (!busy && MemRead && legal) ? load_val : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (!CLEAR_ON_RESET || (&cnt_q)) state_d = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
    end
  end

  assign Read_data  = rdata_q;
  assign Read_valid = rvalid_q;
  assign Misaligned = mis_q;
  assign Busy       = busy;

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be: directed scenarios plus randomized
// accesses checked against a byte-array reference model.
module tb_data_memory_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] Read_data;
  logic        Read_valid;
  logic        Busy;
  logic        Misaligned;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] bytes_m [1024];

  data_memory_be #(.DEPTH_BITS(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemSize    (MemSize),
    .MemSigned  (MemSigned),
    .Read_data  (Read_data),
    .Read_valid (Read_valid),
    .Busy       (Busy),
    .Misaligned (Misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Reference model: 1 KiB of bytes, address taken modulo 1024 (aliasing).
  function automatic bit m_legal(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return addr[0] == 1'b0;
      2'd2:    return addr[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] size,
                                         input logic sgn);
    int base;
    logic [31:0] v;
    base = int'(addr[9:0]);
    v = '0;
    case (size)
      2'd0: begin
        v[7:0] = bytes_m[base];
        if (sgn && v[7]) v[31:8] = '1;
      end
      2'd1: begin
        v[15:0] = {bytes_m[base+1], bytes_m[base]};
        if (sgn && v[15]) v[31:16] = '1;
      end
      2'd2: v = {bytes_m[base+3], bytes_m[base+2], bytes_m[base+1], bytes_m[base]};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void m_store(input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [1:0] size);
    int base;
    base = int'(addr[9:0]);
    for (int i = 0; i < (1 << size); i++) bytes_m[base+i] = wd[8*i +: 8];
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 1024; i++) bytes_m[i] = 8'h00;
  endfunction

  // Drive one request for one clock edge, then capture the registered response.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] size, input logic sgn,
                        output logic [31:0] o_data, output logic o_valid, output logic o_mis);
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = wd;
    MemSize    = size;
    MemSigned  = sgn;
    @(posedge clk);
    #1;
    o_data   = Read_data;
    o_valid  = Read_valid;
    o_mis    = Misaligned;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Counts edges while Busy is high (bounded), optionally issuing a load at 0x40 throughout.
  task automatic wait_busy(input logic load, output int n, output logic saw);
    n   = 0;
    saw = 1'b0;
    MemRead = load;
    Address = 32'h40;
    MemSize = 2'd2;
    while (Busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      saw = saw | Read_valid | Misaligned;
    end
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic saw;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_busy: got %b expected 1", Busy);
    end
    n_cmp++;
    if ({Read_valid, Misaligned, Read_data} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b mis=%b data=%h expected all 0",
               Read_valid, Misaligned, Read_data);
    end
    rst = 1'b0;
    wait_busy(1'b0, n, saw);
    m_clear();
    n_cmp++;
    if (n !== 256) begin
      n_err++;
      $display("FAIL reset_busy_len: got %0d expected 256", n);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    logic v, m;
    int n;
    logic saw;
    access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 2'd2, 1'b0, d, v, m);
    access(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'hDEADBEEF || v !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_preload: got data=%h valid=%b expected deadbeef/1", d, v);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_busy(1'b1, n, saw);
    m_clear();
    n_cmp++;
    if (n !== 256) begin
      n_err++;
      $display("FAIL sweep_busy_len: got %0d expected 256", n);
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_busy_ignore: got response %b expected 0", saw);
    end
    access(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h0 || v !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_cleared: got data=%h valid=%b expected 00000000/1", d, v);
    end
  endtask

  task automatic test_subword();
    logic [31:0] d;
    logic v, m;
    access(1'b0, 1'b1, 32'h10, 32'h12345678, 2'd2, 1'b0, d, v, m);
    access(1'b0, 1'b1, 32'h11, 32'hFFFFFF80, 2'd0, 1'b0, d, v, m);
    m_store(32'h10, 32'h12345678, 2'd2);
    m_store(32'h11, 32'hFFFFFF80, 2'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h12348078 || v !== 1'b1) begin
      n_err++;
      $display("FAIL sub_word_load: got %h expected 12348078", d);
    end
    access(1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b1, d, v, m);
    n_cmp++;
    if (d !== 32'hFFFFFF80) begin
      n_err++;
      $display("FAIL sub_byte_signed: got %h expected ffffff80", d);
    end
    access(1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h00000080) begin
      n_err++;
      $display("FAIL sub_byte_unsigned: got %h expected 00000080", d);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, d, v, m);
    n_cmp++;
    if (d !== 32'hFFFF8078) begin
      n_err++;
      $display("FAIL sub_half_signed: got %h expected ffff8078", d);
    end
    access(1'b1, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h00001234) begin
      n_err++;
      $display("FAIL sub_half_unsigned: got %h expected 00001234", d);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    logic v, m;
    access(1'b0, 1'b1, 32'h12, 32'hAAAAAAAA, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (m !== 1'b1 || v !== 1'b0) begin
      n_err++;
      $display("FAIL mis_word_store: got mis=%b valid=%b expected 1/0", m, v);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h12348078 || m !== 1'b0) begin
      n_err++;
      $display("FAIL mis_store_blocked: got data=%h mis=%b expected 12348078/0", d, m);
    end
    access(1'b1, 1'b0, 32'h13, 32'h0, 2'd1, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h0 || v !== 1'b1 || m !== 1'b1) begin
      n_err++;
      $display("FAIL mis_half_load: got data=%h valid=%b mis=%b expected 0/1/1", d, v, m);
    end
    access(1'b1, 1'b0, 32'h0, 32'h0, 2'd3, 1'b0, d, v, m);
    n_cmp++;
    if (m !== 1'b1 || d !== 32'h0) begin
      n_err++;
      $display("FAIL mis_size11: got mis=%b data=%h expected 1/0", m, d);
    end
    access(1'b1, 1'b1, 32'h21, 32'h55555555, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (m !== 1'b1 || v !== 1'b1) begin
      n_err++;
      $display("FAIL mis_both: got mis=%b valid=%b expected 1/1", m, v);
    end
    access(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, d, v, m);
    n_cmp++;
    if (m !== 1'b0 || v !== 1'b0 || d !== 32'h0) begin
      n_err++;
      $display("FAIL mis_pulse_end: got mis=%b valid=%b data=%h expected 0/0/0", m, v, d);
    end
  endtask

  task automatic test_read_before_write();
    logic [31:0] d;
    logic v, m;
    access(1'b0, 1'b1, 32'h20, 32'h11111111, 2'd2, 1'b0, d, v, m);
    access(1'b1, 1'b1, 32'h20, 32'h22222222, 2'd2, 1'b0, d, v, m);
    m_store(32'h20, 32'h22222222, 2'd2);
    n_cmp++;
    if (d !== 32'h11111111 || v !== 1'b1) begin
      n_err++;
      $display("FAIL rbw_old: got %h expected 11111111", d);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h22222222) begin
      n_err++;
      $display("FAIL rbw_new: got %h expected 22222222", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v, m;
    access(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 2'd2, 1'b0, d, v, m);
    m_store(32'h400, 32'hCAFEF00D, 2'd2);
    access(1'b1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'hCAFEF00D || v !== 1'b1) begin
      n_err++;
      $display("FAIL alias_load: got data=%h valid=%b expected cafef00d/1", d, v);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (d !== 32'h12348078 || v !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: got data=%h valid=%b expected 12348078/1", d, v);
    end
    access(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, d, v, m);
    n_cmp++;
    if (v !== 1'b0 || d !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_idle: got valid=%b data=%h expected 0/0", v, d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, addr, wd, exp_d;
    logic v, m, rd, wr, sgn, lg;
    logic [1:0] size;
    for (int k = 0; k < 400; k++) begin
      addr  = $urandom & 32'hFFFF_FC3F;
      wd    = $urandom;
      size  = 2'($urandom_range(0, 3));
      rd    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      lg    = m_legal(size, addr);
      exp_d = (rd && lg) ? m_load(addr, size, sgn) : 32'h0;
      access(rd, wr, addr, wd, size, sgn, d, v, m);
      if (wr && lg) m_store(addr, wd, size);
      n_cmp++;
      if (v !== rd || d !== exp_d || m !== ((rd || wr) && !lg)) begin
        n_err++;
        $display("FAIL random[%0d] addr=%h size=%0d rd=%b wr=%b: got v=%b d=%h m=%b expected v=%b d=%h m=%b",
                 k, addr, size, rd, wr, v, d, m, rd, exp_d, (rd || wr) && !lg);
      end
    end
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    logic saw;
    Address = 32'h10;
    MemSize = 2'd2;
    MemRead = 1'b1;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
    n_cmp++;
    if (Read_valid !== 1'b0 || Busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_discard: got valid=%b busy=%b expected 0/1", Read_valid, Busy);
    end
    rst = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_sweep_busy: got %b expected 1", Busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_busy(1'b0, n, saw);
    m_clear();
    n_cmp++;
    if (n !== 256) begin
      n_err++;
      $display("FAIL mid_sweep_len: got %0d expected 256", n);
    end
  endtask

  initial begin
    rst        = 1'b1;
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemSize    = 2'd0;
    MemSigned  = 1'b0;
    m_clear();
    test_reset();
    test_sweep();
    test_subword();
    test_misaligned();
    test_read_before_write();
    test_back_to_back();
    test_random();
    test_mid_sweep_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
Byte-addressable data memory for the pipelined CPU MEM stage, replacing the word-only store. Supports byte, halfword and word stores via lane enables. Loads are registered with one-cycle latency and can be sign- or zero-extended. Misaligned accesses are flagged, and a sequential clear sweep runs after reset.

Parameters:
DEPTH_BITS, 8, log2 of word count (DEPTH = 2^DEPTH_BITS words of 32 bits)
CLEAR_ON_RESET, 1, 1: zero every word after reset via INIT sweep; 0: contents untouched by reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
Address  input  32  byte address; word index = Address[DEPTH_BITS+1:2], upper bits ignored (aliasing)
Write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
MemRead  input  1  load request this cycle
MemWrite  input  1  store request this cycle
MemSize  input  2  00 byte, 01 half, 10 word, 11 illegal
MemSigned  input  1  1: sign-extend sub-word loads; 0: zero-extend
Read_data  output  32  registered load result
Read_valid  output  1  one-cycle pulse, Read_data valid
Busy  output  1  high during INIT; requests ignored
Misaligned  output  1  one-cycle pulse for a rejected access

Behaviour:
- Reset: rst high at a posedge sets state INIT, sweep counter 0, Read_data=0, Read_valid=0, Misaligned=0, Busy=1.
- INIT (CLEAR_ON_RESET=1): writes 0 to word[counter] each cycle. After writing DEPTH-1, the next state is IDLE. Busy is high for exactly DEPTH cycles after rst deasserts.
- INIT (CLEAR_ON_RESET=0): one cycle in INIT, then IDLE. Memory is not written.
- rst asserted mid-INIT restarts the sweep at 0. rst asserted in IDLE discards any in-flight load, so Read_valid=0 next cycle.
- While Busy=1, MemRead and MemWrite are ignored: no write, no Read_valid, no Misaligned.
- Alignment:
  - Byte is always legal.
  - Half requires Address[0]=0.
  - Word requires Address[1:0]=00.
  - MemSize=11 is always illegal.
- Illegal access (read or write, not Busy): no memory change. Misaligned=1 on the next cycle. If MemRead, Read_valid=1 with Read_data=0.
- Store (IDLE, MemWrite, legal), committed at the posedge:
  - byte: lane Address[1:0] <= Write_data[7:0]
  - half: lanes {Address[1],1} and {Address[1],0} <= Write_data[15:0], little-endian
  - word: all lanes <= Write_data
  - other lanes are unchanged
- Load (IDLE, MemRead, legal): the word is sampled at the posedge, and Read_data/Read_valid appear the following cycle (latency 1).
  - Field selected by size/offset as for a store.
  - Extended per MemSigned; MemSigned is ignored for word loads.
- No valid load: Read_valid=0 and Read_data=0 on the next cycle.
- MemRead and MemWrite in the same cycle, same word: the load returns pre-write contents (read-before-write). The store still commits.
- Back-to-back loads give one result per cycle. A load issued the cycle after a store to the same word sees the new data.
- MemRead and MemWrite both illegal in the same cycle: a single Misaligned pulse.

Test Plan:
- Reset sweep: store word 0xDEADBEEF at 0x40, pulse rst 1 cycle → Busy=1 for exactly 256 cycles. A load from 0x40 issued during Busy gives Read_valid=0. A load after Busy falls returns 0x00000000.
- Sub-word stores and loads:
  - Store word 0x12345678 at 0x10, then store byte 0x80 at 0x11 → word load at 0x10 = 0x12348078.
  - Signed byte load at 0x11 = 0xFFFFFF80. Unsigned byte load = 0x00000080.
  - Signed half load at 0x10 = 0xFFFF8078. Unsigned half load at 0x12 = 0x00001234.
- Misalignment:
  - Word store 0xAAAAAAAA at 0x12 → Misaligned=1 for one cycle; word at 0x10 is unchanged.
  - Half load at 0x13 → Read_valid=1, Read_data=0, Misaligned=1.
  - MemSize=11 at 0x0 → Misaligned=1.
- Read-before-write: word at 0x20 holds 0x11111111. Same-cycle load + word store of 0x22222222 → Read_data=0x11111111. Next load → 0x22222222.
- Aliasing and latency: store word 0xCAFEF00D at 0x400 (DEPTH_BITS=8) → word load at 0x0 returns 0xCAFEF00D exactly one cycle after issue. Consecutive loads at 0x0 and 0x10 give Read_valid high on two consecutive cycles.
- Mid-sweep reset: assert rst at sweep cycle 100 → Busy stays high for a further 256 cycles after rst deasserts.
